// File: rtl/memmap_ctrl.sv
// memmap_ctrl: host byte-stream initiator for the memmap register-file port.
// A command byte selects write or read, a burst length (1..8) and a start
// address. Writes turn each following data byte into a one-cycle write pulse;
// reads fetch registers one at a time and return them on the tx byte stream.
module memmap_ctrl #(
  parameter int ADDR_BITS = 2,
  parameter int READ_LAT  = 1
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic [7:0]           rx_data_i,
  input  logic                 rx_valid_i,
  output logic                 rx_ready_o,
  output logic [7:0]           tx_data_o,
  output logic                 tx_valid_o,
  input  logic                 tx_ready_i,
  output logic                 write_o,
  output logic [ADDR_BITS-1:0] addr_o,
  output logic [7:0]           data_o,
  input  logic [7:0]           data_i,
  output logic                 busy_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WDATA,
    S_RWAIT,
    S_RSEND
  } state_t;

  localparam logic [1:0] LAT = 2'(READ_LAT);

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [1:0]            r_wait;
  logic [ADDR_BITS-1:0]  r_addr;
  logic [7:0]            r_data;
  logic                  r_write;
  logic [7:0]            r_tx_data;
  logic                  r_tx_valid;
  logic                  r_rx_ready;

  logic                  w_rx_acc;
  logic                  w_tx_acc;
  logic [3:0]            w_len;
  logic [ADDR_BITS-1:0]  w_addr_inc;

  // Handshakes use only registered ready/valid, so neither output depends on
  // the partner's valid/ready combinationally.
  assign w_rx_acc   = rx_valid_i & r_rx_ready;
  assign w_tx_acc   = r_tx_valid & tx_ready_i;
  assign w_len      = {1'b0, rx_data_i[6:4]} + 4'd1;
  assign w_addr_inc = r_addr + ADDR_BITS'(1);

  // Command decode, write-burst sequencing and read fetch/return in one FSM.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_wait     <= 2'd0;
      r_addr     <= '0;
      r_data     <= 8'd0;
      r_write    <= 1'b0;
      r_tx_data  <= 8'd0;
      r_tx_valid <= 1'b0;
      r_rx_ready <= 1'b0;
    end else begin
      r_write <= 1'b0;
      // A write pulse retires on this edge: step to the next address. A new
      // command accepted on the same edge overrides this with its start.
      if (r_write) begin
        r_addr <= w_addr_inc;
      end
      case (r_state)
        S_IDLE: begin
          r_rx_ready <= 1'b1;
          if (w_rx_acc) begin
            r_addr <= rx_data_i[ADDR_BITS-1:0];
            r_cnt  <= w_len;
            if (rx_data_i[7]) begin
              r_state <= S_WDATA;
            end else begin
              r_state    <= S_RWAIT;
              r_wait     <= LAT;
              r_rx_ready <= 1'b0;
            end
          end
        end
        S_WDATA: begin
          if (w_rx_acc) begin
            r_data  <= rx_data_i;
            r_write <= 1'b1;
            r_cnt   <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
              r_state <= S_IDLE;
            end
          end
        end
        S_RWAIT: begin
          // Wait for the register file's read latency before sampling.
          if (r_wait == 2'd0) begin
            r_tx_data  <= data_i;
            r_tx_valid <= 1'b1;
            r_state    <= S_RSEND;
          end else begin
            r_wait <= r_wait - 2'd1;
          end
        end
        S_RSEND: begin
          if (w_tx_acc) begin
            r_tx_valid <= 1'b0;
            r_addr     <= w_addr_inc;
            r_cnt      <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
              r_state    <= S_IDLE;
              r_rx_ready <= 1'b1;
            end else begin
              r_state <= S_RWAIT;
              r_wait  <= LAT;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rx_ready_o = r_rx_ready;
  assign tx_data_o  = r_tx_data;
  assign tx_valid_o = r_tx_valid;
  assign write_o    = r_write;
  assign addr_o     = r_addr;
  assign data_o     = r_data;
  assign busy_o     = (r_state != S_IDLE) | r_write;

endmodule
